// File: rtl/store_commit_buffer_pkg.sv
// rtl/store_commit_buffer_pkg.sv - shared store-buffer types and sizing constants
//
// Purpose: constants and record layout shared by the store commit buffer, the
// ROB and the reservation stations.
//   STB_DEPTH       default number of store-buffer entries
//   ROB_IDX_WIDTH   width of a ROB slot index (also used by ROB and RS)
//   STB_ADDR_WIDTH  store address width
//   STB_DATA_WIDTH  store data width
//   stb_entry_t     {valid, committed, addr, data, rob_index} record for one entry

package store_commit_buffer_pkg;

    localparam int STB_DEPTH      = 8;
    localparam int ROB_IDX_WIDTH  = 4;
    localparam int STB_ADDR_WIDTH = 64;
    localparam int STB_DATA_WIDTH = 64;

    typedef struct packed {
        logic                      valid;
        logic                      committed;
        logic [STB_ADDR_WIDTH-1:0] addr;
        logic [STB_DATA_WIDTH-1:0] data;
        logic [ROB_IDX_WIDTH-1:0]  rob_index;
    } stb_entry_t;

endpackage

// File: rtl/store_commit_buffer_stb_fwd_match.sv
// rtl/store_commit_buffer_stb_fwd_match.sv - youngest-first store-to-load address search
//
// Ports:
//   head       oldest entry slot; age order runs head, head+1, ... (mod DEPTH)
//   ent_valid  per-slot valid bits
//   ent_addr   per-slot store addresses
//   ent_data   per-slot store data
//   ld_addr    load address being looked up
//   fwd_hit    some valid entry has exactly ld_addr
//   fwd_data   data of the youngest exact match
//   fwd_stall  no exact match, but some valid entry lies within 8 bytes of ld_addr

module stb_fwd_match #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 64,
    parameter int PTR_W  = 3
) (
    input  logic [PTR_W-1:0]  head,
    input  logic [DEPTH-1:0]  ent_valid,
    input  logic [ADDR_W-1:0] ent_addr [DEPTH],
    input  logic [63:0]       ent_data [DEPTH],
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              fwd_hit,
    output logic [63:0]       fwd_data,
    output logic              fwd_stall
);

    // Difference taken one bit wider than the address so that addresses near
    // the top and bottom of the space cannot alias into a small distance.
    function automatic logic addr_near(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        logic [ADDR_W:0] diff;
        logic [ADDR_W:0] mag;
        diff = {1'b0, a} - {1'b0, b};
        mag  = diff[ADDR_W] ? (~diff + 1'b1) : diff;
        return mag < (ADDR_W+1)'(8);
    endfunction

    logic             near_any;
    logic [PTR_W-1:0] slot;

    // Walk oldest to youngest; a later match overwrites an earlier one, so the
    // surviving hit is the youngest store to that address.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        near_any = 1'b0;
        slot     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + PTR_W'(k);
            if (ent_valid[slot]) begin
                if (ent_addr[slot] == ld_addr) begin
                    fwd_hit  = 1'b1;
                    fwd_data = ent_data[slot];
                end else if (addr_near(ent_addr[slot], ld_addr)) begin
                    near_any = 1'b1;
                end
            end
        end
        fwd_stall = near_any & ~fwd_hit;
    end

endmodule

// File: rtl/store_commit_buffer.sv
// rtl/store_commit_buffer.sv - post-commit store buffer between LS unit and dmem
//
// Ports:
//   in_clk, in_rst                     clock, asynchronous active-low reset
//   in_st_valid/addr/data/rob_index    store issue from the LS unit
//   out_st_ready                       space for one more store
//   in_rob_commit_done/is_st           ROB head commits (and whether it is a store)
//   in_flush                           discard every uncommitted entry
//   in_ld_addr                         load lookup address
//   out_fwd_hit/data/stall             forwarding result for in_ld_addr
//   out_dmem_w_enable/addr/wval        registered dmem write of the drained head entry
//   out_empty                          buffer holds nothing
//   out_err                            sticky: store commit arrived with nothing to commit

module store_commit_buffer
    import store_commit_buffer_pkg::*;
#(
    parameter int DEPTH     = STB_DEPTH,
    parameter int ROB_IDX_W = ROB_IDX_WIDTH,
    parameter int ADDR_W    = STB_ADDR_WIDTH
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_st_valid,
    input  logic [ADDR_W-1:0]    in_st_addr,
    input  logic [63:0]          in_st_data,
    input  logic [ROB_IDX_W-1:0] in_st_rob_index,
    output logic                 out_st_ready,
    input  logic                 in_rob_commit_done,
    input  logic                 in_rob_commit_is_st,
    input  logic                 in_flush,
    input  logic [ADDR_W-1:0]    in_ld_addr,
    output logic                 out_fwd_hit,
    output logic [63:0]          out_fwd_data,
    output logic                 out_fwd_stall,
    output logic                 out_dmem_w_enable,
    output logic [ADDR_W-1:0]    out_dmem_addr,
    output logic [63:0]          out_dmem_wval,
    output logic                 out_empty,
    output logic                 out_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  commit_count;
    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_committed;
    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [63:0]       ent_data [DEPTH];

    logic             commit_req;
    logic             commit_ok;
    logic             commit_bad;
    logic             drain;
    logic             enq;
    logic [CNT_W-1:0] cc_after;
    logic [PTR_W-1:0] commit_slot;
    logic [PTR_W-1:0] tail_n;
    logic [CNT_W-1:0] count_n;
    logic [CNT_W-1:0] cc_n;
    logic [DEPTH-1:0] flush_clear;

    assign out_st_ready = (count < CNT_W'(DEPTH));
    assign out_empty    = (count == '0);

    assign commit_req  = in_rob_commit_done & in_rob_commit_is_st;
    assign commit_ok   = commit_req & (commit_count != count);
    assign commit_bad  = commit_req & (commit_count == count);
    assign drain       = ent_valid[head] & ent_committed[head];
    assign enq         = in_st_valid & out_st_ready & ~in_flush;
    // Committed entries always form the prefix head .. head+commit_count-1.
    assign cc_after    = commit_count + CNT_W'(commit_ok);
    assign commit_slot = head + commit_count[PTR_W-1:0];

    always_comb begin
        cc_n        = cc_after - CNT_W'(drain);
        flush_clear = '0;
        if (in_flush) begin
            // Everything past the (post-commit) committed prefix goes away.
            tail_n  = head + cc_after[PTR_W-1:0];
            count_n = cc_after - CNT_W'(drain);
            for (int i = 0; i < DEPTH; i++) begin
                flush_clear[i] = ({1'b0, PTR_W'(i) - head} >= cc_after);
            end
        end else begin
            tail_n  = tail + PTR_W'(enq);
            count_n = count + CNT_W'(enq) - CNT_W'(drain);
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            commit_count      <= '0;
            ent_valid         <= '0;
            ent_committed     <= '0;
            out_dmem_w_enable <= 1'b0;
            out_dmem_addr     <= '0;
            out_dmem_wval     <= '0;
            out_err           <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            head              <= head + PTR_W'(drain);
            tail              <= tail_n;
            count             <= count_n;
            commit_count      <= cc_n;
            out_err           <= out_err | commit_bad;
            out_dmem_w_enable <= drain;
            if (drain) begin
                out_dmem_addr       <= ent_addr[head];
                out_dmem_wval       <= ent_data[head];
                ent_valid[head]     <= 1'b0;
                ent_committed[head] <= 1'b0;
            end
            if (commit_ok) begin
                ent_committed[commit_slot] <= 1'b1;
            end
            if (enq) begin
                ent_valid[tail]     <= 1'b1;
                ent_committed[tail] <= 1'b0;
                ent_addr[tail]      <= in_st_addr;
                ent_data[tail]      <= in_st_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (flush_clear[i]) begin
                    ent_valid[i]     <= 1'b0;
                    ent_committed[i] <= 1'b0;
                end
            end
        end
    end

    stb_fwd_match #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .PTR_W (PTR_W)
    ) u_fwd_match (
        .head     (head),
        .ent_valid(ent_valid),
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .ld_addr  (in_ld_addr),
        .fwd_hit  (out_fwd_hit),
        .fwd_data (out_fwd_data),
        .fwd_stall(out_fwd_stall)
    );

    // A store offered while full is dropped by the buffer; the LS unit must never do this.
    a_no_store_when_full: assert property (@(posedge in_clk) disable iff (!in_rst)
        !(in_st_valid && !out_st_ready));

    a_rob_index_known: assert property (@(posedge in_clk) disable iff (!in_rst)
        in_st_valid |-> !$isunknown(in_st_rob_index));

endmodule

// File: tb/tb_store_commit_buffer.sv
// tb/tb_store_commit_buffer.sv - directed self-checking bench for store_commit_buffer

module tb_store_commit_buffer;

    logic        in_clk;
    logic        in_rst;
    logic        in_st_valid;
    logic [63:0] in_st_addr;
    logic [63:0] in_st_data;
    logic [3:0]  in_st_rob_index;
    logic        out_st_ready;
    logic        in_rob_commit_done;
    logic        in_rob_commit_is_st;
    logic        in_flush;
    logic [63:0] in_ld_addr;
    logic        out_fwd_hit;
    logic [63:0] out_fwd_data;
    logic        out_fwd_stall;
    logic        out_dmem_w_enable;
    logic [63:0] out_dmem_addr;
    logic [63:0] out_dmem_wval;
    logic        out_empty;
    logic        out_err;

    int tests_run = 0;
    int tests_failed = 0;

    logic [63:0] wr_addr_q [$];
    logic [63:0] wr_data_q [$];

    store_commit_buffer dut (
        .in_clk             (in_clk),
        .in_rst             (in_rst),
        .in_st_valid        (in_st_valid),
        .in_st_addr         (in_st_addr),
        .in_st_data         (in_st_data),
        .in_st_rob_index    (in_st_rob_index),
        .out_st_ready       (out_st_ready),
        .in_rob_commit_done (in_rob_commit_done),
        .in_rob_commit_is_st(in_rob_commit_is_st),
        .in_flush           (in_flush),
        .in_ld_addr         (in_ld_addr),
        .out_fwd_hit        (out_fwd_hit),
        .out_fwd_data       (out_fwd_data),
        .out_fwd_stall      (out_fwd_stall),
        .out_dmem_w_enable  (out_dmem_w_enable),
        .out_dmem_addr      (out_dmem_addr),
        .out_dmem_wval      (out_dmem_wval),
        .out_empty          (out_empty),
        .out_err            (out_err)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    always @(posedge in_clk) begin
        #1;
        if (out_dmem_w_enable === 1'b1) begin
            wr_addr_q.push_back(out_dmem_addr);
            wr_data_q.push_back(out_dmem_wval);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic store(input logic [63:0] a, input logic [63:0] d, input logic [3:0] rob);
        in_st_valid     = 1'b1;
        in_st_addr      = a;
        in_st_data      = d;
        in_st_rob_index = rob;
        tick();
        in_st_valid     = 1'b0;
    endtask

    task automatic commit(input logic with_flush);
        in_rob_commit_done  = 1'b1;
        in_rob_commit_is_st = 1'b1;
        in_flush            = with_flush;
        tick();
        in_rob_commit_done  = 1'b0;
        in_rob_commit_is_st = 1'b0;
        in_flush            = 1'b0;
    endtask

    task automatic load_check(input string tag, input logic [63:0] a,
                              input logic hit, input logic [63:0] d, input logic stall);
        in_ld_addr = a;
        #1;
        check({tag, "_hit"}, 64'(out_fwd_hit), 64'(hit));
        if (hit) check({tag, "_data"}, out_fwd_data, d);
        check({tag, "_stall"}, 64'(out_fwd_stall), 64'(stall));
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        in_rst = 1'b0;
        in_st_valid = 1'b0;
        in_st_addr = '0;
        in_st_data = '0;
        in_st_rob_index = '0;
        in_rob_commit_done = 1'b0;
        in_rob_commit_is_st = 1'b0;
        in_flush = 1'b0;
        in_ld_addr = '0;
        ticks(2);
        check("rst_empty", 64'(out_empty), 64'd1);
        check("rst_ready", 64'(out_st_ready), 64'd1);
        check("rst_wen", 64'(out_dmem_w_enable), 64'd0);
        check("rst_err", 64'(out_err), 64'd0);
        in_rst = 1'b1;
        tick();

        // 1: uncommitted store stays put but forwards
        store(64'h40, 64'd5, 4'd2);
        ticks(10);
        check("t1_no_writes", 64'(wr_addr_q.size()), 64'd0);
        check("t1_wen", 64'(out_dmem_w_enable), 64'd0);
        load_check("t1_ld40", 64'h40, 1'b1, 64'd5, 1'b0);

        // 2: commit, then drain on the following edge
        commit(1'b0);
        check("t2_wen_commit_edge", 64'(out_dmem_w_enable), 64'd0);
        tick();
        check("t2_wen", 64'(out_dmem_w_enable), 64'd1);
        check("t2_addr", out_dmem_addr, 64'h40);
        check("t2_wval", out_dmem_wval, 64'd5);
        tick();
        check("t2_empty", 64'(out_empty), 64'd1);
        check("t2_wen_off", 64'(out_dmem_w_enable), 64'd0);

        // 3: youngest match wins, near miss stalls, distance 8 does not
        clear_writes();
        store(64'h40, 64'd1, 4'd3);
        store(64'h40, 64'd2, 4'd4);
        load_check("t3_ld40", 64'h40, 1'b1, 64'd2, 1'b0);
        load_check("t3_ld44", 64'h44, 1'b0, 64'd0, 1'b1);
        load_check("t3_ld3c", 64'h3c, 1'b0, 64'd0, 1'b1);
        load_check("t3_ld48", 64'h48, 1'b0, 64'd0, 1'b0);
        commit(1'b0);
        commit(1'b0);
        ticks(3);
        check("t3_nwrites", 64'(wr_addr_q.size()), 64'd2);
        if (wr_data_q.size() == 2) begin
            check("t3_w0", wr_data_q[0], 64'd1);
            check("t3_w1", wr_data_q[1], 64'd2);
        end

        // 4: flush with a same-cycle commit keeps exactly the two committed stores
        clear_writes();
        store(64'h100, 64'h11, 4'd5);
        store(64'h108, 64'h22, 4'd6);
        store(64'h110, 64'h33, 4'd7);
        commit(1'b0);
        commit(1'b1);
        load_check("t4_ld110_flushed", 64'h110, 1'b0, 64'd0, 1'b0);
        ticks(5);
        check("t4_nwrites", 64'(wr_addr_q.size()), 64'd2);
        if (wr_addr_q.size() == 2) begin
            check("t4_a0", wr_addr_q[0], 64'h100);
            check("t4_d0", wr_data_q[0], 64'h11);
            check("t4_a1", wr_addr_q[1], 64'h108);
            check("t4_d1", wr_data_q[1], 64'h22);
        end
        check("t4_empty", 64'(out_empty), 64'd1);

        // 5: fill, ready back after one drain, pointer wrap over 20 stores
        clear_writes();
        for (int i = 0; i < 8; i++) store(64'h200 + 64'(8 * i), 64'(i), 4'(i));
        check("t5_full_ready", 64'(out_st_ready), 64'd0);
        commit(1'b0);
        check("t5_ready_commit_edge", 64'(out_st_ready), 64'd0);
        tick();
        check("t5_ready_after_drain", 64'(out_st_ready), 64'd1);
        for (int i = 0; i < 7; i++) commit(1'b0);
        for (int i = 8; i < 20; i++) begin
            store(64'h200 + 64'(8 * i), 64'(i), 4'(i));
            commit(1'b0);
        end
        ticks(5);
        check("t5_nwrites", 64'(wr_addr_q.size()), 64'd20);
        if (wr_addr_q.size() == 20) begin
            for (int i = 0; i < 20; i++) begin
                check($sformatf("t5_a%0d", i), wr_addr_q[i], 64'h200 + 64'(8 * i));
                check($sformatf("t5_d%0d", i), wr_data_q[i], 64'(i));
            end
        end
        check("t5_empty", 64'(out_empty), 64'd1);

        // 6: commit on empty is sticky; async reset mid-drain
        commit(1'b0);
        check("t6_err", 64'(out_err), 64'd1);
        ticks(3);
        check("t6_err_held", 64'(out_err), 64'd1);
        store(64'h300, 64'd7, 4'd1);
        commit(1'b0);
        tick();
        check("t6_wen_before_rst", 64'(out_dmem_w_enable), 64'd1);
        #2 in_rst = 1'b0;
        #1;
        check("t6_rst_wen", 64'(out_dmem_w_enable), 64'd0);
        check("t6_rst_addr", out_dmem_addr, 64'd0);
        check("t6_rst_wval", out_dmem_wval, 64'd0);
        check("t6_rst_err", 64'(out_err), 64'd0);
        check("t6_rst_empty", 64'(out_empty), 64'd1);
        check("t6_rst_ready", 64'(out_st_ready), 64'd1);
        @(negedge in_clk);
        in_rst = 1'b1;
        ticks(2);
        check("t6_post_rst_wen", 64'(out_dmem_w_enable), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
